// File: rtl/preg_free_list_pkg.sv
// ---------------------------------------------------------------------------
// preg_free_list_pkg
// Shared sizing for the physical-register free list.
//   PREG_NUM  : physical registers in the file (power of two)
//   AREG_NUM  : architectural registers, mapped to pregs 0..AREG_NUM-1 at reset
//   SLOTS     : rename / commit width
//   TAG_W     : width of a physical register tag (ReNameRegBus)
//   PTR_W     : free-list pointer width, index plus one wrap bit
// ---------------------------------------------------------------------------
package preg_free_list_pkg;

  localparam int PREG_NUM = 128;
  localparam int AREG_NUM = 32;
  localparam int SLOTS    = 4;
  localparam int TAG_W    = $clog2(PREG_NUM);
  localparam int PTR_W    = TAG_W + 1;
  localparam int OFF_W    = $clog2(SLOTS);
  localparam int CNT_W    = $clog2(SLOTS) + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // The wrap bit only matters for full/empty; the array is addressed by the rest.
  function automatic tag_t ptrIndex(input ptr_t p);
    return p[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/preg_free_list_slot_compact.sv
// ---------------------------------------------------------------------------
// preg_free_list_slot_compact
// Turns a per-slot request mask into compacted offsets: each slot gets the
// number of set bits below it, so the j-th requesting slot sees offset j.
// Ports:
//   i_mask   : per-slot request bits
//   o_offset : per-slot prefix count of set bits in lower slots
//   o_count  : total number of set bits
// ---------------------------------------------------------------------------
module preg_free_list_slot_compact
  import preg_free_list_pkg::*;
(
  input  logic [SLOTS-1:0]            i_mask,
  output logic [SLOTS-1:0][OFF_W-1:0] o_offset,
  output logic [CNT_W-1:0]            o_count
);

  logic [CNT_W-1:0] w_run;

  // Running prefix sum; a slot's offset is the count before adding itself.
  always_comb begin
    w_run    = '0;
    o_offset = '0;
    for (int k = 0; k < SLOTS; k++) begin
      o_offset[k] = w_run[OFF_W-1:0];
      w_run       = w_run + CNT_W'(i_mask[k]);
    end
    o_count = w_run;
  end

endmodule

// File: rtl/preg_free_list.sv
// ---------------------------------------------------------------------------
// preg_free_list
// Physical-register allocator for rename. A circular list of free tags is
// consumed from a speculative head, refilled at the tail by commit-time
// releases, and the speculative head is rolled back to the committed head on
// flush.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_freeStop          : stall, no allocation this cycle
//   i_freeFlash         : flush, roll speculative head back to committed head
//   i_allocReq          : per rename slot, needs a destination preg
//   o_allocGrant        : every requesting slot is served this cycle
//   o_allocAddr         : slot k tag in bits [7k+6:7k], zero when not granted
//   i_commitAllocNum    : committed instructions that had allocated a preg
//   i_freeAble          : per commit slot, releases the tag in i_freeAddr
//   i_freeAddr          : released tags, slot k in bits [7k+6:7k]
//   o_freeCount         : free entries as seen by speculative allocation
// ---------------------------------------------------------------------------
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_freeStop,
  input  logic                   i_freeFlash,
  input  logic [SLOTS-1:0]       i_allocReq,
  output logic                   o_allocGrant,
  output logic [SLOTS*TAG_W-1:0] o_allocAddr,
  input  logic [CNT_W-1:0]       i_commitAllocNum,
  input  logic [SLOTS-1:0]       i_freeAble,
  input  logic [SLOTS*TAG_W-1:0] i_freeAddr,
  output logic [PTR_W-1:0]       o_freeCount
);

  tag_t r_entry [PREG_NUM];
  ptr_t r_specHead;
  ptr_t r_commitHead;
  ptr_t r_tail;

  logic [SLOTS-1:0][OFF_W-1:0] w_allocOff;
  logic [SLOTS-1:0][OFF_W-1:0] w_freeOff;
  logic [CNT_W-1:0]            w_allocNum;
  logic [CNT_W-1:0]            w_freeNum;
  ptr_t                        w_freeCount;
  logic                        w_grant;

  preg_free_list_slot_compact u_allocCompact (
    .i_mask   (i_allocReq),
    .o_offset (w_allocOff),
    .o_count  (w_allocNum)
  );

  preg_free_list_slot_compact u_freeCompact (
    .i_mask   (i_freeAble),
    .o_offset (w_freeOff),
    .o_count  (w_freeNum)
  );

  // The wrap bit makes a full list (128) differ from an empty one (0).
  assign w_freeCount = r_tail - r_specHead;
  assign o_freeCount = w_freeCount;

  // Tags freed this cycle are not counted yet, so the check uses the old tail.
  assign w_grant = !i_rst && (w_allocNum != '0) && (PTR_W'(w_allocNum) <= w_freeCount)
                   && !i_freeStop && !i_freeFlash;
  assign o_allocGrant = w_grant;

  // Requesting slots read consecutive entries from the speculative head.
  always_comb begin
    o_allocAddr = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (w_grant && i_allocReq[k]) begin
        o_allocAddr[k*TAG_W +: TAG_W] = r_entry[ptrIndex(r_specHead + PTR_W'(w_allocOff[k]))];
      end
    end
  end

  // Commit and free are non-speculative and proceed during stall or flush;
  // a flush includes this cycle's commits in the restored head.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_specHead   <= '0;
      r_commitHead <= '0;
      r_tail       <= PTR_W'(PREG_NUM - AREG_NUM);
    end else begin
      r_commitHead <= r_commitHead + PTR_W'(i_commitAllocNum);
      r_tail       <= r_tail + PTR_W'(w_freeNum);
      if (i_freeFlash) begin
        r_specHead <= r_commitHead + PTR_W'(i_commitAllocNum);
      end else if (w_grant) begin
        r_specHead <= r_specHead + PTR_W'(w_allocNum);
      end
    end
  end

  // Reset image holds every non-architectural preg; released tags land at the tail.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PREG_NUM; i++) begin
        r_entry[i] <= (i < PREG_NUM - AREG_NUM) ? tag_t'(AREG_NUM + i) : '0;
      end
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (i_freeAble[k]) begin
          r_entry[ptrIndex(r_tail + PTR_W'(w_freeOff[k]))] <= i_freeAddr[k*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Inputs the surrounding pipeline must never produce.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (i_commitAllocNum <= CNT_W'(SLOTS));
      assert ((9'(w_freeCount) + 9'(w_freeNum)) <= 9'(PREG_NUM));
      assert (PTR_W'(i_commitAllocNum) <= PTR_W'(r_specHead - r_commitHead));
    end
  end

endmodule
